// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freeze,
// halt and timeout. Optional perf counters via `define HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_START,
    S_RUN,
    S_WAIT,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [WW-1:0]   r_wait;
  logic            r_halted;
  logic            r_tout;

  logic            w_active;
  logic            w_freeze;
  logic            w_hit;
  logic            w_loaduse;
  logic            w_flush;
  logic            w_tout;

  // MEM_WAIT behaves like RUN once mem_ready releases the freeze.
  assign w_active  = (r_state == S_RUN) | (r_state == S_WAIT);
  assign w_freeze  = w_active & mem_req & ~mem_ready;
  assign w_hit     = ex_mem_read & (|ex_rt) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign w_loaduse = w_active & ~w_freeze & w_hit;
  assign w_flush   = w_active & ~w_freeze & ~w_loaduse &
                     (id_branch_taken | id_jump);
  assign w_tout    = w_freeze & (r_wait == WW'(MEM_TIMEOUT - 1));

  // Controller FSM with registered halt/timeout status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_START;
      r_wait   <= '0;
      r_halted <= 1'b0;
      r_tout   <= 1'b0;
    end else begin
      unique case (r_state)
        S_START: begin
          r_state <= S_RUN;
          r_wait  <= '0;
        end
        S_RUN, S_WAIT: begin
          if (w_freeze) begin
            if (w_tout) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
              r_tout   <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_wait  <= r_wait + WW'(1);
            end
          end else begin
            r_wait <= '0;
            if (halt_req) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign halted      = r_halted;
  assign mem_timeout = r_tout;

  // Stage enables and NOP inserts; the selectors are mutually exclusive.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    unique case (1'b1)
      (r_state == S_START): begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
      end
      (r_state == S_HALT): begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      w_freeze: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
      end
      w_loaduse: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      w_flush: begin
        ifid_flush = 1'b1;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_cyc;
  logic [31:0] r_stall;
  logic [31:0] r_flush;

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc   <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (w_active)
        r_cyc <= r_cyc + 32'd1;
      if (w_freeze | w_loaduse)
        r_stall <= r_stall + 32'd1;
      if ((r_state == S_RUN) & w_flush)
        r_flush <= r_flush + 32'd1;
    end
  end

  assign cycle_cnt = r_cyc;
  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;
`else
  assign cycle_cnt = 32'd0;
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic against a rule-level reference model.
module tb_hazard_controller;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, id_branch_taken, id_jump;
  logic        mem_req, mem_ready, halt_req;
  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_bubble, memwb_bubble;
  logic        halted, mem_timeout;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [6:0]  outs;

  int n_run  = 0;
  int n_fail = 0;

  // model state
  bit m_boot, m_halt, m_tout;
  int m_wcnt;
  int unsigned m_cyc, m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read),
    .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .exmem_write(exmem_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble),
    .halted(halted), .mem_timeout(mem_timeout),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                 ifid_flush, idex_bubble, memwb_bubble};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned cnt_exp(int unsigned v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_boot  = 1; m_halt = 0; m_tout = 0; m_wcnt = 0;
    m_cyc   = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_mem_read = 0;
    id_branch_taken = 0; id_jump = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick(string tag);
    logic [6:0] exp;
    bit frz, lu, br;
    #2;
    frz = mem_req && !mem_ready;
    lu  = !frz && ex_mem_read && ex_rt != 0 &&
          (ex_rt == id_rs || ex_rt == id_rt);
    br  = !frz && !lu && (id_branch_taken || id_jump);
    if (m_boot)      exp = 7'b0000111;
    else if (m_halt) exp = 7'b0011110;
    else if (frz)    exp = 7'b0000001;
    else if (lu)     exp = 7'b0011010;
    else if (br)     exp = 7'b1111100;
    else             exp = 7'b1111000;
    chk({tag, ".outs"}, 32'(outs), 32'(exp));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".tout"}, 32'(mem_timeout), 32'(m_tout));
    chk({tag, ".cyc"}, cycle_cnt, cnt_exp(m_cyc));
    chk({tag, ".stall"}, stall_cnt, cnt_exp(m_stall));
    chk({tag, ".flush"}, flush_cnt, cnt_exp(m_flush));
    @(posedge clk);
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt) begin
      m_cyc++;
      if (frz || lu) m_stall++;
      if (br && m_wcnt == 0) m_flush++;
      if (frz) begin
        m_wcnt++;
        if (m_wcnt == TO) begin
          m_halt = 1;
          m_tout = 1;
        end
      end else begin
        m_wcnt = 0;
        if (halt_req) m_halt = 1;
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic do_reset(string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, ".rst_outs"}, 32'(outs), 32'h07);
    chk({tag, ".rst_halted"}, 32'(halted), 32'h0);
    chk({tag, ".rst_tout"}, 32'(mem_timeout), 32'h0);
    chk({tag, ".rst_cnt"}, cycle_cnt | stall_cnt | flush_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    do_reset("init");
    tick("start");
    tick("idle");

    // load-use on rs
    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
    tick("lu_rs");
    ex_mem_read = 0;
    tick("lu_after");

    // zero register never stalls
    ex_mem_read = 1; ex_rt = 0; id_rt = 0; id_rs = 0;
    tick("zero_reg");
    chk("zero_reg.pc", 32'(pc_write), 32'h1);
    idle();

    // branch suppressed by stall, then taken
    do_reset("br");
    tick("br_start");
    ex_mem_read = 1; ex_rt = 5; id_rt = 5; id_branch_taken = 1;
    tick("br_stall");
    ex_mem_read = 0;
    tick("br_take");
    idle();
`ifdef HAZARD_PERF_CNT_EN
    chk("br.flush_cnt", flush_cnt, 32'd1);
`endif
    id_jump = 1;
    tick("jump");
    idle();

    // 3 frozen cycles then release
    mem_req = 1; mem_ready = 0;
    repeat (3) tick("mw_frz");
    mem_ready = 1;
    tick("mw_rel");
    idle();
    tick("mw_run");

    // halt_req ignored while frozen, honored on release
    mem_req = 1; mem_ready = 0; halt_req = 1;
    repeat (2) tick("hq_frz");
    mem_ready = 1;
    tick("hq_rel");
    idle();
    repeat (2) tick("hq_halt");
    chk("hq.halted", 32'(halted), 32'h1);

    // timeout
    do_reset("to");
    tick("to_start");
    mem_req = 1; mem_ready = 0;
    repeat (20) tick("to_frz");
    chk("to.tout", 32'(mem_timeout), 32'h1);
    chk("to.halted", 32'(halted), 32'h1);
    idle();
    tick("to_hold");

    // reset mid-freeze
    do_reset("rf");
    tick("rf_start");
    mem_req = 1; mem_ready = 0;
    repeat (2) tick("rf_frz");
    do_reset("rf_mid");
    idle();
    tick("rf_start2");
    tick("rf_run");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom_range(0, 1));
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_jump = ($urandom_range(0, 7) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      halt_req = ($urandom_range(0, 40) == 0);
      tick("rnd");
      if (m_halt && $urandom_range(0, 3) == 0) do_reset("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: the maximum number of consecutive MEM_WAIT cycles before a timeout halt.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have ports ex_rt (input, 5 bits) and ex_mem_read (input, 1 bit): destination register and load flag of the instruction in EX.
REQ-006 SHALL have ports id_branch_taken and id_jump, input, 1 bit each: control transfer resolved in ID.
REQ-007 SHALL have ports mem_req and mem_ready, input, 1 bit each: MEM-stage data access request and completion.
REQ-008 SHALL have port halt_req, input, 1 bit: halt instruction retiring in WB.
REQ-009 SHALL have outputs pc_write, ifid_write, idex_write and exmem_write, 1 bit each: register enables.
REQ-010 SHALL have outputs ifid_flush, idex_bubble and memwb_bubble, 1 bit each: insert NOP.
REQ-011 SHALL have outputs halted and mem_timeout, 1 bit each: both sticky status flags.
REQ-012 SHALL have outputs cycle_cnt, stall_cnt and flush_cnt, 32 bits each: performance counters.

Function
REQ-013 SHALL implement the states START, RUN, MEM_WAIT and HALT.
REQ-014 In START, outputs SHALL be frozen (all *_write=0, all bubbles/flush=1); the next state SHALL be RUN unconditionally.
REQ-015 A memory freeze SHALL occur in RUN or MEM_WAIT when mem_req=1 and mem_ready=0.
- Same cycle: all *_write=0, memwb_bubble=1; other bubbles and flush=0.
- Next state: MEM_WAIT.
REQ-016 In MEM_WAIT, mem_ready=1 SHALL release the freeze combinationally in that cycle, and the next state SHALL be RUN.
REQ-017 A wait counter SHALL count consecutive frozen cycles and clear on release; reaching MEM_TIMEOUT SHALL set mem_timeout=1 and move the state to HALT.
REQ-018 A load-use stall SHALL be detected when ex_mem_read=1, ex_rt!=0 and ex_rt equals id_rs or id_rt.
- Same cycle: pc_write=0, ifid_write=0, idex_bubble=1; idex_write and exmem_write stay 1.
- Lasts exactly one cycle, since the bubble clears the condition.
REQ-019 When id_branch_taken or id_jump is 1 and no stall or freeze is active, the block SHALL drive ifid_flush=1 for one cycle, with pc_write=1.
REQ-020 Priority SHALL be: HALT > memory freeze > load-use stall > flush.
- A branch coincident with a stall is suppressed; it is re-evaluated next cycle.
REQ-021 halt_req=1 in RUN SHALL move the state to HALT at the next edge.
- HALT: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1; exmem_write=1 so older instructions drain.
- halted=1; exit only via reset.
REQ-022 halt_req during a memory freeze SHALL be ignored until the freeze releases.
REQ-023 With no event active in RUN, all *_write SHALL be 1 and all bubbles/flush SHALL be 0.

Reset
REQ-024 While reset=1, asynchronously: state=START, counters=0, wait counter=0, halted=0, mem_timeout=0, and outputs at the START values.
REQ-025 Reset asserted mid-freeze or mid-stall SHALL abort the operation immediately, with no residual stall after deassertion beyond the single START cycle.

Configuration
REQ-026 With HAZARD_PERF_CNT_EN defined, the counters SHALL operate as follows (all wrap modulo 2^32):
- cycle_cnt: increments every cycle not in START or HALT.
- stall_cnt: increments on every load-use or freeze cycle.
- flush_cnt: increments on every ifid_flush cycle in RUN.
REQ-027 Without HAZARD_PERF_CNT_EN, the counter ports SHALL remain present and tied to 0, with no counter registers.

Verification
REQ-028 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; stall_cnt +1.
REQ-029 Zero register: ex_mem_read=1, ex_rt=0, id_rt=0 -> no stall; all *_write=1.
REQ-030 Branch vs. stall: id_branch_taken=1 together with the load-use stall -> ifid_flush=0 that cycle; next cycle, branch only -> ifid_flush=1, flush_cnt=1.
REQ-031 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles, release on the 4th; state returns to RUN.
REQ-032 Timeout: mem_req=1, mem_ready=0 held for 20 cycles with MEM_TIMEOUT=16 -> mem_timeout=1 and halted=1 after the 16th frozen cycle; both stay set.
REQ-033 Reset mid-freeze: assert reset during MEM_WAIT -> outputs go to START values without waiting for a clock edge; 1 START cycle after deassertion, then RUN with counters=0.
